// File: rtl/scrambler_pkg.sv
// Keystream definitions shared by the video scrambler transmitter and receiver.
// Both ends import this package so their LFSR sequences and key mux stay bit-identical.
package scrambler_pkg;

    localparam logic [3:0] LFSR4_SEED = 4'hA;
    localparam logic [7:0] LFSR8_SEED = 8'hB4;

    typedef enum logic [1:0] {
        FIXED    = 2'b00,
        LFSR4    = 2'b01,
        LFSR8    = 2'b10,
        COMBINED = 2'b11
    } scr_mode_t;

    function automatic logic [3:0] lfsr4_step(input logic [3:0] l);
        return {l[2:0], l[3] ^ l[2]};
    endfunction

    function automatic logic [7:0] lfsr8_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [15:0] make_key(
        input scr_mode_t   mode,
        input logic [3:0]  l4,
        input logic [7:0]  l8,
        input logic [15:0] fixed
    );
        logic [15:0] key;
        case (mode)
            FIXED:    key = fixed;
            LFSR4:    key = {l4, l4, l4, l4};
            LFSR8:    key = {l8, l8};
            default:  key = {l8, l4, l4};
        endcase
        return key;
    endfunction

endpackage

// File: rtl/scr_keygen.sv
// Keystream generator: LFSR registers, seed/step control and key mux.
// The key reflects the effective state of the beat being emitted (seeds on a reseed beat).
module scr_keygen
    import scrambler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        reseed,
    input  logic [1:0]  mode,
    input  logic [15:0] fixed_key,
    input  logic        en,
    output logic [15:0] key
);

    logic [3:0] l4_q, l4_d, l4_eff;
    logic [7:0] l8_q, l8_d, l8_eff;

    always_comb begin
        l4_eff = reseed ? LFSR4_SEED : l4_q;
        l8_eff = reseed ? LFSR8_SEED : l8_q;
        key    = en ? make_key(scr_mode_t'(mode), l4_eff, l8_eff, fixed_key) : 16'h0000;
    end

    // LFSRs only move when a pixel is actually emitted; dropped and stalled beats freeze them.
    always_comb begin
        l4_d = l4_q;
        l8_d = l8_q;
        if (advance) begin
            l4_d = lfsr4_step(l4_eff);
            l8_d = lfsr8_step(l8_eff);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l4_q <= LFSR4_SEED;
            l8_q <= LFSR8_SEED;
        end else begin
            l4_q <= l4_d;
            l8_q <= l8_d;
        end
    end

endmodule

// File: rtl/video_descrambler_rx.sv
// Receive-side RGB565 descrambler with frame-length sync tracking and a one-stage output register.
// Optional saturating error counter is built when DESCRAMBLER_ERRCNT_EN is defined.
module video_descrambler_rx
    import scrambler_pkg::*;
#(
    parameter int FRAME_PIXELS = 76800,
    parameter int CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        descramble_en,
    input  logic [1:0]  mode_select,
    input  logic [15:0] fixed_key,
    input  logic [15:0] in_pixel,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_pixel,
    output logic        out_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_count
);

    localparam logic ST_UNSYNC = 1'b0;
    localparam logic ST_SYNCED = 1'b1;

    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic              state_q, state_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       fixed_key_q, fixed_key_d;
    logic              en_q, en_d;
    logic [15:0]       out_pixel_q, out_pixel_d;
    logic              out_sof_q, out_sof_d;
    logic              out_valid_q, out_valid_d;
    logic              sync_err_q, sync_err_d;

    logic              accept;
    logic              emit;
    logic              frame_full;
    logic [1:0]        mode_eff;
    logic [15:0]       fixed_eff;
    logic              en_eff;
    logic [15:0]       key;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign frame_full = (pix_cnt_q == FRAME_END);

    // The SOF pixel already uses the configuration being sampled with it.
    assign mode_eff  = in_sof ? mode_select   : mode_q;
    assign fixed_eff = in_sof ? fixed_key     : fixed_key_q;
    assign en_eff    = in_sof ? descramble_en : en_q;

    scr_keygen u_keygen (
        .clk       (clk),
        .reset     (reset),
        .advance   (emit),
        .reseed    (in_sof),
        .mode      (mode_eff),
        .fixed_key (fixed_eff),
        .en        (en_eff),
        .key       (key)
    );

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        mode_d      = mode_q;
        fixed_key_d = fixed_key_q;
        en_d        = en_q;
        emit        = 1'b0;
        sync_err_d  = 1'b0;
        if (accept) begin
            if (in_sof) begin
                // A SOF always restarts the frame; arriving early is a short-frame error.
                emit        = 1'b1;
                sync_err_d  = (state_q == ST_SYNCED) && !frame_full;
                state_d     = ST_SYNCED;
                pix_cnt_d   = CNT_ONE;
                mode_d      = mode_select;
                fixed_key_d = fixed_key;
                en_d        = descramble_en;
            end else if (state_q == ST_SYNCED) begin
                if (frame_full) begin
                    sync_err_d = 1'b1;
                    state_d    = ST_UNSYNC;
                    pix_cnt_d  = '0;
                end else begin
                    emit      = 1'b1;
                    pix_cnt_d = pix_cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        out_pixel_d = out_pixel_q;
        out_sof_d   = out_sof_q;
        out_valid_d = out_valid_q;
        if (emit) begin
            out_pixel_d = in_pixel ^ key;
            out_sof_d   = in_sof;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_UNSYNC;
            pix_cnt_q   <= '0;
            mode_q      <= 2'b10;
            fixed_key_q <= 16'h0000;
            en_q        <= 1'b1;
            out_pixel_q <= 16'h0000;
            out_sof_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            mode_q      <= mode_d;
            fixed_key_q <= fixed_key_d;
            en_q        <= en_d;
            out_pixel_q <= out_pixel_d;
            out_sof_q   <= out_sof_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign out_pixel = out_pixel_q;
    assign out_sof   = out_sof_q;
    assign out_valid = out_valid_q;
    assign locked    = (state_q == ST_SYNCED);
    assign sync_err  = sync_err_q;

`ifdef DESCRAMBLER_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Counts in the same edge as the sync_err pulse it accounts for.
    always_comb begin
        err_count_d = err_count_q;
        if (sync_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= 8'h00;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_video_descrambler_rx.sv
// Randomised scoreboard bench for video_descrambler_rx with a keystream-index reference model.
// Expected beats are queued by the driver and checked by an independent output monitor.
module tb_video_descrambler_rx;

    localparam int FP = 4;
`ifdef DESCRAMBLER_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        descramble_en = 1'b1;
    logic [1:0]  mode_select = 2'b00;
    logic [15:0] fixed_key = 16'h0000;
    logic [15:0] in_pixel = 16'h0000;
    logic        in_sof = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_pixel;
    logic        out_sof;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        locked;
    logic        sync_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    video_descrambler_rx #(.FRAME_PIXELS(FP)) dut (
        .clk           (clk),
        .reset         (reset),
        .descramble_en (descramble_en),
        .mode_select   (mode_select),
        .fixed_key     (fixed_key),
        .in_pixel      (in_pixel),
        .in_sof        (in_sof),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_pixel     (out_pixel),
        .out_sof       (out_sof),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .locked        (locked),
        .sync_err      (sync_err),
        .err_count     (err_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] pix;
        logic        sof;
    } beat_t;
    beat_t exp_q[$];

    // Reference model state: frame position as a plain index, not LFSR registers.
    bit          m_synced;
    int          m_idx;
    int          m_mode;
    logic [15:0] m_fixed;
    bit          m_en;
    bit          m_ov;
    bit          m_err;
    int          m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Key of the idx-th pixel of a frame: idx LFSR steps from the seeds.
    function automatic logic [15:0] ref_key(input int mode, input logic [15:0] fk, input int idx);
        logic [3:0] a;
        logic [7:0] b;
        logic [15:0] k;
        a = 4'hA;
        b = 8'hB4;
        for (int i = 0; i < idx; i++) begin
            a = {a[2:0], a[3] ^ a[2]};
            b = {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
        end
        case (mode)
            0:       k = fk;
            1:       k = {a, a, a, a};
            2:       k = {b, b};
            default: k = {b, a, a};
        endcase
        return k;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_synced = 0;
        m_idx    = 0;
        m_mode   = 2;
        m_fixed  = 16'h0000;
        m_en     = 1;
        m_ov     = 0;
        m_err    = 0;
        m_cnt    = 0;
    endtask

    task automatic model_beat(input bit acc, input bit s, input logic [15:0] p, input bit r,
                              input logic [1:0] md, input logic [15:0] fk, input bit en);
        bit emit;
        logic [15:0] k;
        beat_t b;
        emit  = 0;
        k     = 16'h0000;
        m_err = 0;
        if (acc) begin
            if (s) begin
                if (m_synced && m_idx != FP) m_err = 1;
                m_mode   = int'(md);
                m_fixed  = fk;
                m_en     = en;
                m_synced = 1;
                k        = ref_key(m_mode, m_fixed, 0);
                m_idx    = 1;
                emit     = 1;
            end else if (m_synced) begin
                if (m_idx == FP) begin
                    m_err    = 1;
                    m_synced = 0;
                end else begin
                    k     = ref_key(m_mode, m_fixed, m_idx);
                    m_idx = m_idx + 1;
                    emit  = 1;
                end
            end
        end
        if (m_err) m_cnt = ERRCNT ? ((m_cnt < 255) ? m_cnt + 1 : 255) : 0;
        if (emit) begin
            b.pix = m_en ? (p ^ k) : p;
            b.sof = s;
            exp_q.push_back(b);
            m_ov = 1;
        end else if (r) begin
            m_ov = 0;
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [15:0] p, input bit r,
                        input logic [1:0] md, input logic [15:0] fk, input bit en);
        bit exp_rdy;
        @(posedge clk);
        #1;
        in_valid      = v;
        in_sof        = s;
        in_pixel      = p;
        out_ready     = r;
        mode_select   = md;
        fixed_key     = fk;
        descramble_en = en;
        @(negedge clk);
        check("locked", 32'(locked), 32'(m_synced));
        check("sync_err", 32'(sync_err), 32'(m_err));
        check("err_count", 32'(err_count), 32'(m_cnt));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        exp_rdy = !m_ov || r;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        model_beat(v && exp_rdy, s, p, r, md, fk, en);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pixel", 32'(out_pixel), 32'd0);
        check("rst_out_sof", 32'(out_sof), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic rnd_step();
        step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 16'($urandom),
             $urandom_range(0, 3) != 0, 2'($urandom), 16'($urandom), $urandom_range(0, 5) != 0);
    endtask

    // Output monitor: whenever a beat is presented it must match the oldest expected beat.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got pix %h sof %0b, none expected", out_pixel, out_sof);
                end else begin
                    check("out_pixel", 32'(out_pixel), 32'(exp_q[0].pix));
                    check("out_sof", 32'(out_sof), 32'(exp_q[0].sof));
                    if (out_ready) begin
                        $display("[MON] beat pix=%h sof=%0b", out_pixel, out_sof);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Unsynced: non-SOF beats dropped.
        step(1, 0, 16'h1234, 1, 2'b10, 16'h0, 1);
        step(1, 0, 16'h4321, 1, 2'b10, 16'h0, 1);
        // Known keystream vectors.
        step(1, 1, 16'hB4B4, 1, 2'b10, 16'h0, 1);
        step(1, 0, 16'h6969, 1, 2'b10, 16'h0, 1);
        step(1, 1, 16'hAAAA, 1, 2'b01, 16'h0, 1);
        step(1, 0, 16'h5555, 1, 2'b01, 16'h0, 1);
        step(1, 1, 16'hB4AA, 1, 2'b11, 16'h0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 16'($urandom), 1, 2'b00, 16'hFFFF, 0);
        // Fixed key and pass-through full frames.
        step(1, 1, 16'h0F0F, 1, 2'b00, 16'hC3A5, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 16'($urandom), 1, 2'b11, 16'h1111, 0);
        step(1, 1, 16'h7E7E, 1, 2'b11, 16'h0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 16'($urandom), 1, 2'b01, 16'h0, 1);
        // Long frame: extra pixel is dropped and sync is lost, then regained.
        step(1, 1, 16'h0001, 1, 2'b10, 16'h0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 16'($urandom), 1, 2'b10, 16'h0, 1);
        step(1, 1, 16'h0002, 1, 2'b01, 16'h0, 1);
        // Backpressure mid-frame for 5 cycles, then continue.
        step(1, 0, 16'hABCD, 1, 2'b01, 16'h0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 16'h5A5A, 0, 2'b01, 16'h0, 1);
        step(1, 0, 16'h5A5A, 1, 2'b01, 16'h0, 1);
        step(1, 1, 16'h3333, 1, 2'b11, 16'h0, 1);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) rnd_step();
        // Back-to-back SOFs: each one after the first is a short frame.
        for (int i = 0; i < 302; i++) step(1, 1, 16'($urandom), 1, 2'($urandom), 16'($urandom), 1);
        step(1, 0, 16'h0000, 1, 2'b10, 16'h0, 1);
        // Reset with a pending output beat.
        step(1, 1, 16'h1357, 0, 2'b10, 16'h0, 1);
        step(0, 0, 16'h0000, 0, 2'b10, 16'h0, 1);
        do_reset();
        step(1, 0, 16'h2468, 1, 2'b10, 16'h0, 1);
        step(1, 0, 16'h1111, 1, 2'b10, 16'h0, 1);
        step(1, 1, 16'hB4B4, 1, 2'b10, 16'h0, 1);
        step(1, 0, 16'h6969, 1, 2'b10, 16'h0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0000, 1, 2'b10, 16'h0, 1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
